// File: rtl/serial_operand_feeder.sv
// ============================================================================
// Module      : serial_operand_feeder
// Description : Presents two operands and a carry LSB-first, one bit per
//               BIT_CYCLES clocks, to a bit-serial full-adder FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_operand_feeder #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 3,
    localparam int c_IDX_W   = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               op_cin,
    input  logic               abort,
    input  logic               carry_fb,
    output logic               start,
    output logic               rst,
    output logic               A,
    output logic               B,
    output logic               CIN,
    output logic [c_IDX_W-1:0] bit_idx,
    output logic               busy,
    output logic               done
);

    localparam int c_SLOT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(BIT_CYCLES - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [WIDTH-1:0]    r_sh_a;
    logic [WIDTH-1:0]    r_sh_b;
    logic                r_cin;
    logic [c_IDX_W-1:0]  r_bit_idx;
    logic [c_SLOT_W-1:0] r_slot;
    logic                r_rst;
    logic                w_last_slot;
    logic                w_last_bit;

    assign w_last_slot = (r_slot == c_SLOT_LAST);
    assign w_last_bit  = (r_bit_idx == c_IDX_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // abort outranks every transition out of an active state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (in_valid) w_state_nxt = c_START;
            c_START: w_state_nxt = abort ? c_IDLE : c_SHIFT;
            c_SHIFT: begin
                if (abort) begin
                    w_state_nxt = c_IDLE;
                end else if (w_last_slot && w_last_bit) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sh_a    <= '0;
            r_sh_b    <= '0;
            r_cin     <= 1'b0;
            r_bit_idx <= '0;
            r_slot    <= '0;
            r_rst     <= 1'b0;
        end else begin
            r_rst <= abort && (r_state != c_IDLE);
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_sh_a    <= op_a;
                        r_sh_b    <= op_b;
                        r_cin     <= op_cin;
                        r_bit_idx <= '0;
                        r_slot    <= '0;
                    end
                end
                c_START: r_slot <= '0;
                c_SHIFT: begin
                    if (w_last_slot) begin
                        r_slot <= '0;
                        // carry after the top bit has no consumer
                        if (!w_last_bit) begin
                            r_sh_a    <= {1'b0, r_sh_a[WIDTH-1:1]};
                            r_sh_b    <= {1'b0, r_sh_b[WIDTH-1:1]};
                            r_cin     <= carry_fb;
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                        end
                    end else begin
                        r_slot <= r_slot + c_SLOT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready = (r_state == c_IDLE);
        start    = (r_state == c_START);
        busy     = (r_state == c_START) || (r_state == c_SHIFT);
        done     = (r_state == c_DONE);
        rst      = r_rst;
        bit_idx  = r_bit_idx;
        A        = busy & r_sh_a[0];
        B        = busy & r_sh_b[0];
        CIN      = busy & r_cin;
    end

endmodule

`default_nettype wire

// File: doc/serial_operand_feeder.md
# serial_operand_feeder

Upstream stage of the bit-serial full-adder state machine. Accepts a pair of WIDTH-bit operands plus carry-in through a valid/ready handshake, issues the one-cycle `start` pulse, then presents the operands LSB-first on the single-bit `A`/`B`/`CIN` lines, holding each bit for BIT_CYCLES clocks. The carry fed back from the adder's `COUT` is captured at the end of each bit slot and becomes the next bit's `CIN`. `abort` drives the adder's `rst` line and returns the feeder to idle.

## Interface
- WIDTH, 8: operand width in bits; ≥2.
- BIT_CYCLES, 3: clocks each bit is held on `A`/`B`/`CIN`; ≥1. The default matches the adder's S1→S2→S3 rotation.
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  feeder idle and able to accept; equals (state==IDLE).
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_cin  in  1  carry-in for bit 0.
- abort  in  1  cancel the current operation.
- carry_fb  in  1  carry returned from the adder's `COUT`.
- start  out  1  one-cycle start pulse to the adder.
- rst  out  1  one-cycle abort pulse to the adder's `rst`.
- A  out  1  current bit of op_a.
- B  out  1  current bit of op_b.
- CIN  out  1  current carry-in.
- bit_idx  out  $clog2(WIDTH)  index of the bit currently presented.
- busy  out  1  high in START and SHIFT.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, START, SHIFT, DONE. All state and datapath elements are registered, and all outputs decode from registers.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: load shift registers sh_a←op_a and sh_b←op_b, set cin_reg←op_cin, bit_idx←0, slot←0, then go to START.
- **START**
  - `start`=1 for exactly this cycle.
  - `A`=sh_a[0], `B`=sh_b[0], `CIN`=cin_reg.
  - Next state is SHIFT with slot=0. START does not count toward any bit slot.
- **SHIFT**
  - `A`=sh_a[0], `B`=sh_b[0], `CIN`=cin_reg.
  - slot increments each cycle.
  - When slot==BIT_CYCLES-1:
    - cin_reg←carry_fb.
    - sh_a and sh_b shift right by one, zero-filled.
    - slot←0 and bit_idx←bit_idx+1.
    - If bit_idx==WIDTH-1, go to DONE instead. bit_idx does not wrap past WIDTH-1.
- **DONE**
  - `done`=1 for one cycle; `A`/`B`/`CIN`=0.
  - Next state is IDLE.
  - The final carry_fb sample is discarded.
- **abort**
  - In START, SHIFT or DONE, `abort` sampled high forces next state IDLE and sets `rst`=1 for the following single cycle.
  - In that case `done` is not asserted.
  - `abort` takes priority over every transition, including SHIFT→DONE.
- `abort` in IDLE is ignored: no `rst` pulse, and a simultaneous `in_valid` is still accepted.
- `in_valid` outside IDLE is ignored, and the operands are not captured.
- Outside START and SHIFT, `A`, `B` and `CIN` are 0.

## Timing
- While RST is asserted and after its release:
  - state=IDLE, `in_ready`=1.
  - `start`, `rst`, `A`, `B`, `CIN`, `busy`, `done`=0.
  - bit_idx, slot, cin_reg and the shift registers are 0.
- RST asserted mid-operation: outputs go to the reset values immediately (asynchronous). No `rst` pulse is generated.
- Handshake accepted at edge k:
  - `start` is high in cycle k+1.
  - SHIFT occupies cycles k+2 … k+1+WIDTH·BIT_CYCLES.
  - `done` is high in cycle k+2+WIDTH·BIT_CYCLES.
  - `in_ready` returns in cycle k+3+WIDTH·BIT_CYCLES.
  - With defaults: `done` in k+26, ready in k+27.
- carry_fb is sampled on the edge ending the last cycle of each bit slot. It must be valid during that cycle.
- Abort latency: `abort` high in cycle n gives `rst`=1 and `in_ready`=1 in cycle n+1. A new handshake is possible at the end of cycle n+1.
- Throughput: one operation per WIDTH·BIT_CYCLES+3 cycles.

## Test plan
- **Reset.** Drive RST high mid-SHIFT → all outputs 0 and `in_ready`=1 within the same cycle; after release no `start` or `rst` pulse appears.
- **Single operation.** Defaults, op_a=8'hA5, op_b=8'h3C, op_cin=1, carry_fb tied 0:
  - `start` in k+1.
  - `A` sequence (bit order 0…7) is 1,0,1,0,0,1,0,1, each held 3 cycles.
  - `CIN`=1 for bit 0 only.
  - `done` in k+26.
- **Carry feedback.** Toggle carry_fb only in the last slot cycle of bit 2 → `CIN`=1 throughout bit 3 and 0 elsewhere (op_cin=0).
- **Abort.**
  - Assert `abort` in the second cycle of bit 5 → `rst`=1 for one cycle, then IDLE with no `done`.
  - A new operation accepted in the next cycle runs to completion normally.
- **Ignored inputs.**
  - `in_valid` held high throughout an operation → exactly one `start` per operation; the operands change only at IDLE acceptance.
  - `abort` in IDLE → no `rst` pulse.
- **Parameter corner.** WIDTH=2, BIT_CYCLES=1, op_a=2'b10, op_b=2'b01 → `A`=0 then 1, `B`=1 then 0, one cycle each; `done` in k+4.
